// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the fetch PC sequencer: next-PC select encodings,
// sequencer states, default address constants and an alignment helper.
package riscv_pc_pkg;

    localparam logic [1:0] NEXTPC_SEQ  = 2'b00;
    localparam logic [1:0] NEXTPC_JAL  = 2'b01;
    localparam logic [1:0] NEXTPC_JALR = 2'b10;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        PEND = 2'b10
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect detection and target selection for EX-stage jumps/branches.
// With PC_MISALIGN_TRAP_EN defined, misaligned targets are sent to TRAP_VEC.
module pc_target_sel
    import riscv_pc_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic        ex_valid,
    input  logic [1:0]  pc_sel,
    input  logic        cond_taken,
    input  logic [31:0] pc_imm,
    input  logic [31:0] rs1_imm,
    output logic        redir,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] raw_target_s;
    logic        raw_misaligned_s;
    logic        trap_s;
    logic        unused_ok_s;

    // Priority mux over JAL, JALR (bit 0 cleared) and taken branch
    always_comb begin
        raw_target_s = pc_imm;
        case (pc_sel)
            NEXTPC_JAL:  raw_target_s = pc_imm;
            NEXTPC_JALR: raw_target_s = {rs1_imm[31:1], 1'b0};
            default:     raw_target_s = pc_imm;
        endcase
    end

    assign redir            = ex_valid & ((pc_sel == NEXTPC_JAL) | (pc_sel == NEXTPC_JALR) | cond_taken);
    assign raw_misaligned_s = is_misaligned(raw_target_s);

`ifdef PC_MISALIGN_TRAP_EN
    assign trap_s      = raw_misaligned_s;
    assign unused_ok_s = rs1_imm[0];
`else
    assign trap_s      = 1'b0;
    assign unused_ok_s = ^{rs1_imm[0], raw_misaligned_s};
`endif

    // An aligned target is unchanged by clearing bits [1:0], so one expression covers both builds
    assign target     = trap_s ? TRAP_VEC : {raw_target_s[31:2], 2'b00};
    assign misaligned = redir & trap_s;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences imem req/ready, arbitrates stall vs redirect,
// generates flushes and defers redirects behind an unaccepted request.
// Optional build macro: PC_MISALIGN_TRAP_EN (misaligned targets trap to TRAP_VEC).
module pc_sequencer
    import riscv_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  pc_sel,
    input  logic        cond_taken,
    input  logic [31:0] pc_imm,
    input  logic [31:0] rs1_imm,
    input  logic        stall,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ready,
    output logic        if_kill,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misalign
);

    seq_state_e  state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_pc_r;
    logic        held_r;
    logic        kill_r;

    logic        redir_s;
    logic [31:0] target_s;
    logic        misaligned_s;
    logic        if_req_s;
    logic        accept_s;

    pc_target_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_target_sel (
        .ex_valid   (ex_valid),
        .pc_sel     (pc_sel),
        .cond_taken (cond_taken),
        .pc_imm     (pc_imm),
        .rs1_imm    (rs1_imm),
        .redir      (redir_s),
        .target     (target_s),
        .misaligned (misaligned_s)
    );

    // Fetch request: suppressed at boot, forced while a request is held or a redirect is pending
    always_comb begin
        if_req_s = 1'b0;
        case (state_r)
            BOOT:    if_req_s = 1'b0;
            RUN:     if_req_s = ~stall | held_r;
            PEND:    if_req_s = 1'b1;
            default: if_req_s = 1'b0;
        endcase
    end

    assign accept_s = if_req_s & if_ready;

    // Sequencer FSM: PC, pending redirect target, held flag and stale-response kill
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= BOOT;
            pc_r      <= RESET_PC;
            pend_pc_r <= 32'h0000_0000;
            held_r    <= 1'b0;
            kill_r    <= 1'b0;
        end else begin
            held_r <= if_req_s & ~if_ready;
            kill_r <= 1'b0;
            case (state_r)
                BOOT: begin
                    state_r <= RUN;
                end
                RUN: begin
                    if (redir_s && (!held_r || if_ready)) begin
                        pc_r   <= target_s;
                        kill_r <= accept_s;
                    end else if (redir_s) begin
                        // Request still outstanding: address must stay stable until accepted
                        pend_pc_r <= target_s;
                        state_r   <= PEND;
                    end else if (accept_s) begin
                        pc_r <= pc_r + 32'd4;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                PEND: begin
                    if (accept_s) begin
                        pc_r    <= redir_s ? target_s : pend_pc_r;
                        kill_r  <= 1'b1;
                        state_r <= RUN;
                    end else if (redir_s) begin
                        pend_pc_r <= target_s;
                    end else begin
                        pend_pc_r <= pend_pc_r;
                    end
                end
                default: begin
                    state_r <= BOOT;
                end
            endcase
        end
    end

    assign if_req     = if_req_s;
    assign if_addr    = pc_r;
    assign if_kill    = kill_r;
    assign flush_ifid = redir_s;
    assign flush_idex = redir_s;
    assign misalign   = misaligned_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven self-checking bench for pc_sequencer with an expected-output scoreboard.
// Expected misalign/trap values follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        ev;
        logic [1:0]  sel;
        logic        ct;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        stl;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_kill;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] JR_T = TRAP ? 32'h0000_0100 : 32'h0000_0200;
    localparam logic [31:0] MJ_T = TRAP ? 32'h0000_0100 : 32'h0000_1000;
    localparam logic [31:0] PJ_T = TRAP ? 32'h0000_0100 : 32'h0000_0700;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  pc_sel;
    logic        cond_taken;
    logic [31:0] pc_imm;
    logic [31:0] rs1_imm;
    logic        stall;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_kill;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign;

    int checks;
    int failures;
    vec_t vecs[$];
    vec_t exp_q[$];

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .pc_sel     (pc_sel),
        .cond_taken (cond_taken),
        .pc_imm     (pc_imm),
        .rs1_imm    (rs1_imm),
        .stall      (stall),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_kill    (if_kill),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .misalign   (misalign)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step%0d %s actual=%h expected=%h", idx, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ev, input logic [1:0] sel, input logic ct,
                                input logic [31:0] imm, input logic [31:0] rs1, input logic stl,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_kill, input logic e_flush, input logic e_mis);
        vec_t t;
        t.rst = r; t.ev = ev; t.sel = sel; t.ct = ct; t.imm = imm; t.rs1 = rs1;
        t.stl = stl; t.rdy = rdy; t.e_req = e_req; t.e_addr = e_addr;
        t.e_kill = e_kill; t.e_flush = e_flush; t.e_mis = e_mis;
        return t;
    endfunction

    // Drive one cycle of inputs at negedge, queue its expectation, compare mid-cycle
    task automatic step(input int idx, input vec_t t);
        vec_t e;
        @(negedge clk);
        rst = t.rst; ex_valid = t.ev; pc_sel = t.sel; cond_taken = t.ct;
        pc_imm = t.imm; rs1_imm = t.rs1; stall = t.stl; if_ready = t.rdy;
        exp_q.push_back(t);
        #2;
        e = exp_q.pop_front();
        chk(idx, "if_req", {31'd0, if_req}, {31'd0, e.e_req});
        chk(idx, "if_addr", if_addr, e.e_addr);
        chk(idx, "if_kill", {31'd0, if_kill}, {31'd0, e.e_kill});
        chk(idx, "flush_ifid", {31'd0, flush_ifid}, {31'd0, e.e_flush});
        chk(idx, "flush_idex", {31'd0, flush_idex}, {31'd0, e.e_flush});
        chk(idx, "misalign", {31'd0, misalign}, {31'd0, e.e_mis});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; ex_valid = 1'b0; pc_sel = 2'b00; cond_taken = 1'b0;
        pc_imm = 32'd0; rs1_imm = 32'd0; stall = 1'b0; if_ready = 1'b1;

        //           rst  ev    sel    ct    imm            rs1            stl   rdy   req   addr           kill  fl    mis
        // reset, boot, sequential fetch
        vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         1'b0, 1'b0, 1'b0));
        // JAL to 0x100 at pc 0x8 with accept
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h100,       32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h100,       1'b1, 1'b0, 1'b0));
        // JALR to 0x203 (misaligned after bit-0 clear)
        vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,         32'h203,       1'b0, 1'b1, 1'b1, 32'h104,       1'b0, 1'b1, TRAP));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, JR_T,          1'b1, 1'b0, 1'b0));
        // JAL to 0x10, then hold the request and redirect to 0x40
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h10,        32'h0,         1'b0, 1'b1, 1'b1, JR_T + 32'h4,  1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h10,        1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h40,        32'h0,         1'b0, 1'b0, 1'b1, 32'h10,        1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h10,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h10,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h40,        1'b1, 1'b0, 1'b0));
        // held at 0x44, redirect to 0x60 then overwrite with 0x80 in PEND
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h44,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h60,        32'h0,         1'b0, 1'b0, 1'b1, 32'h44,        1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h80,        32'h0,         1'b0, 1'b0, 1'b1, 32'h44,        1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h44,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h80,        1'b1, 1'b0, 1'b0));
        // JAL to 0x20, stall three cycles, then stall together with JAL to 0x300
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h20,        32'h0,         1'b0, 1'b1, 1'b1, 32'h84,        1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 32'h20,        1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 32'h20,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 32'h20,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h300,       32'h0,         1'b1, 1'b1, 1'b0, 32'h20,        1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h300,       1'b0, 1'b0, 1'b0));
        // held request accepted in the same cycle as a redirect behaves as not-held
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h304,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h400,       32'h0,         1'b0, 1'b1, 1'b1, 32'h304,       1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h400,       1'b1, 1'b0, 1'b0));
        // stall does not drop a held request
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h404,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h404,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b1, 32'h404,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h408,       1'b0, 1'b0, 1'b0));
        // reset while in PEND: pending 0x500 is never fetched
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 32'h40C,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h500,       32'h0,         1'b0, 1'b0, 1'b1, 32'h40C,       1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h40C,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         1'b0, 1'b0, 1'b0));
        // PC wrap at the top of the address space
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0));
        // misaligned JAL target
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h1002,      32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         1'b0, 1'b1, TRAP));
        vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, MJ_T,          1'b1, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        // Hand sequence: stall ignored in PEND, and misalign check on a target stored in PEND
        step(100, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, MJ_T + 32'h4, 1'b0, 1'b0, 1'b0));
        step(101, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0,   32'h601, 1'b0, 1'b0, 1'b1, MJ_T + 32'h4, 1'b0, 1'b1, 1'b0));
        step(102, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, MJ_T + 32'h4, 1'b0, 1'b0, 1'b0));
        step(103, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 1'b1, MJ_T + 32'h4, 1'b0, 1'b0, 1'b0));
        step(104, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 32'h600,      1'b1, 1'b0, 1'b0));
        step(105, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 32'h604,      1'b0, 1'b0, 1'b0));
        step(106, mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h702, 32'h0,   1'b0, 1'b0, 1'b1, 32'h604,      1'b0, 1'b1, TRAP));
        step(107, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 32'h604,      1'b0, 1'b0, 1'b0));
        step(108, mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1, PJ_T,         1'b1, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
